// File: rtl/mul_req_scheduler.sv
// Round-robin scheduler sharing one external 32/2x16/4x8 vector multiplier among NUM_REQ requesters.
// Define MUL_SCHED_STATS_EN to add saturating issue/conflict counters.
module mul_req_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]  req_precision,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [NUM_REQ*64-1:0] rsp_data,
  output logic [NUM_REQ-1:0]    rsp_err,
  output logic [31:0]           mul_operand_a,
  output logic [31:0]           mul_operand_b,
  output logic [1:0]            mul_precision,
  input  logic [63:0]           mul_result
`ifdef MUL_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_issue_cnt,
  output logic [31:0]           stat_conflict_cnt
`endif
);
  // Handshakes: a request transfers on a clock edge where req_valid[i] && req_ready[i];
  // a response transfers on an edge where rsp_valid[i] && rsp_ready[i]. Valid never waits on ready.
  localparam int TAG_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    r_pending;
  logic [TAG_W-1:0]      r_ptr;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [NUM_REQ-1:0]    r_rsp_err;
  logic [NUM_REQ*64-1:0] r_rsp_data;
  logic [MUL_LATENCY-1:0] r_pipe_vld;
  logic [TAG_W-1:0]      r_pipe_tag [MUL_LATENCY];

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [TAG_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_gnt_idx;
  logic               w_found;
  logic [1:0]         w_gnt_prec;
  logic               w_illegal;
  logic               w_issue;
  logic               w_tail_vld;
  logic [TAG_W-1:0]   w_tail_tag;

  assign w_elig = req_valid & ~r_pending;

  // Search upward from the pointer with wrap; nothing is granted while reset is held.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = TAG_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && rst && w_elig[w_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
    if (w_found) w_grant[w_gnt_idx] = 1'b1;
  end

  assign w_gnt_prec = req_precision[2*w_gnt_idx +: 2];
  assign w_illegal  = w_found && (w_gnt_prec == 2'b11);
  assign w_issue    = w_found && !w_illegal;

  assign req_ready     = w_grant;
  assign mul_operand_a = w_issue ? req_a[32*w_gnt_idx +: 32] : '0;
  assign mul_operand_b = w_issue ? req_b[32*w_gnt_idx +: 32] : '0;
  assign mul_precision = w_issue ? w_gnt_prec : 2'b10;

  assign w_tail_vld = r_pipe_vld[MUL_LATENCY-1];
  assign w_tail_tag = r_pipe_tag[MUL_LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pipe_vld <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) r_pipe_tag[s] <= '0;
    end else begin
      r_pipe_vld[0] <= w_issue;
      r_pipe_tag[0] <= w_gnt_idx;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        r_pipe_tag[s] <= r_pipe_tag[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gnt_idx == TAG_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + TAG_W'(1);
    end
  end

  // Pending blocks a second op until the slot drains, so a slot write never meets a full slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending   <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= '0;
      r_rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_rsp_valid[i] && rsp_ready[i]) begin
          r_rsp_valid[i]          <= 1'b0;
          r_rsp_err[i]            <= 1'b0;
          r_rsp_data[64*i +: 64]  <= '0;
          r_pending[i]            <= 1'b0;
        end
        if (w_tail_vld && (w_tail_tag == TAG_W'(i))) begin
          r_rsp_valid[i]          <= 1'b1;
          r_rsp_err[i]            <= 1'b0;
          r_rsp_data[64*i +: 64]  <= mul_result;
        end
        if (w_illegal && (w_gnt_idx == TAG_W'(i))) begin
          r_rsp_valid[i]          <= 1'b1;
          r_rsp_err[i]            <= 1'b1;
          r_rsp_data[64*i +: 64]  <= '0;
        end
        if (w_grant[i]) r_pending[i] <= 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;

`ifdef MUL_SCHED_STATS_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_conflict_cnt;
  logic        w_conflict;

  assign w_conflict = |(w_elig & (w_elig - NUM_REQ'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_cnt    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_found && (r_issue_cnt != 32'hFFFF_FFFF)) r_issue_cnt <= r_issue_cnt + 32'd1;
      if (w_conflict && (r_conflict_cnt != 32'hFFFF_FFFF)) r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign stat_issue_cnt    = r_issue_cnt;
  assign stat_conflict_cnt = r_conflict_cnt;
`endif

endmodule
